// File: rtl/oled_pkg.sv
// Shared SSD1331 definitions: command opcodes, panel geometry defaults and the
// tagged byte type carried on the controller's command/data stream.
package oled_pkg;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;
    localparam logic [7:0] CMD_DISP_ON = 8'hAF;
    localparam logic [7:0] CMD_REMAP   = 8'hA0;

    localparam int unsigned DEF_DISP_W = 96;
    localparam int unsigned DEF_DISP_H = 64;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
    } oled_byte_t;

    // Address-window command sequence: SET_COL x0 x1 SET_ROW y0 y1.
    function automatic oled_byte_t cmd_byte(input logic [2:0] idx,
                                            input logic [6:0] x0, input logic [6:0] x1,
                                            input logic [5:0] y0, input logic [5:0] y1);
        oled_byte_t r;
        r.dc = 1'b0;
        case (idx)
            3'd0:    r.b = CMD_SET_COL;
            3'd1:    r.b = {1'b0, x0};
            3'd2:    r.b = {1'b0, x1};
            3'd3:    r.b = CMD_SET_ROW;
            3'd4:    r.b = {2'b00, y0};
            default: r.b = {2'b00, y1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/oled_window_writer.sv
// Turns a rectangle draw request into the SSD1331 address-window commands followed
// by the window's pixel bytes (solid colour or streamed), on a single-slot output.
module oled_window_writer
    import oled_pkg::*;
#(
    parameter int unsigned DISP_W = DEF_DISP_W,
    parameter int unsigned DISP_H = DEF_DISP_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] x0,
    input  logic [6:0] x1,
    input  logic [5:0] y0,
    input  logic [5:0] y1,
    input  logic       fill_solid,
    input  logic [7:0] fill_color,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_dc,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StErr} state_e;

    localparam logic [2:0] CmdLast = 3'd5;

    state_e      state_q, state_d;
    logic [6:0]  x0_q, x1_q;
    logic [5:0]  y0_q, y1_q;
    logic        solid_q;
    logic [7:0]  color_q;
    logic [2:0]  cmd_idx_q;
    logic [12:0] pix_cnt_q;
    logic        out_valid_q;
    oled_byte_t  out_q;
    logic        done_q;

    logic        slot_free, accept, req_ok, cmd_load, data_load, last_hs;
    logic [6:0]  win_w, win_h;
    logic [12:0] win_pixels;

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = (state_q == StIdle) && req_valid;
    assign req_ok    = (x0 <= x1) && (y0 <= y1) && (32'(x1) < DISP_W) && (32'(y1) < DISP_H);
    assign cmd_load  = (state_q == StCmd) && slot_free;
    assign data_load = (state_q == StData) && slot_free && (pix_cnt_q != 13'd0) &&
                       (solid_q || pix_valid);
    // pix_cnt_q counts bytes still to load, so zero plus a handshake means the last byte left.
    assign last_hs   = (state_q == StData) && (pix_cnt_q == 13'd0) && out_valid_q && out_ready;

    assign win_w      = x1_q - x0_q + 7'd1;
    assign win_h      = {1'b0, y1_q} - {1'b0, y0_q} + 7'd1;
    assign win_pixels = 13'(win_w) * 13'(win_h);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = req_ok ? StCmd : StErr;
            StCmd:  if (cmd_load && (cmd_idx_q == CmdLast)) state_d = StData;
            StData: if (last_hs) state_d = StIdle;
            StErr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        err       = (state_q == StErr);
        pix_ready = (state_q == StData) && !solid_q && slot_free && (pix_cnt_q != 13'd0);
        done      = done_q;
        out_valid = out_valid_q;
        out_byte  = out_q.b;
        out_dc    = out_q.dc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            solid_q     <= 1'b0;
            color_q     <= '0;
            cmd_idx_q   <= '0;
            pix_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (accept) begin
                x0_q    <= x0;
                x1_q    <= x1;
                y0_q    <= y0;
                y1_q    <= y1;
                solid_q <= fill_solid;
                color_q <= fill_color;
                if (req_ok) begin
                    out_valid_q <= 1'b1;
                    out_q       <= cmd_byte(3'd0, x0, x1, y0, y1);
                    cmd_idx_q   <= 3'd1;
                end
            end else if (cmd_load) begin
                out_valid_q <= 1'b1;
                out_q       <= cmd_byte(cmd_idx_q, x0_q, x1_q, y0_q, y1_q);
                cmd_idx_q   <= cmd_idx_q + 3'd1;
                if (cmd_idx_q == CmdLast) pix_cnt_q <= win_pixels;
            end else if ((state_q == StData) && slot_free) begin
                if (data_load) begin
                    out_valid_q <= 1'b1;
                    out_q.dc    <= 1'b1;
                    out_q.b     <= solid_q ? color_q : pix_data;
                    pix_cnt_q   <= pix_cnt_q - 13'd1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule
